// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared types and constants for the watch alarm blocks.
//   ring_state_e  : alarm session state (IDLE / RING / SNOOZE)
//   SNOOZE_CNT_W  : width of the per-session snooze counter
//   max_u()       : helper for sizing counters from two parameters
// -----------------------------------------------------------------------------
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } ring_state_e;

    localparam int unsigned SNOOZE_CNT_W = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_ringer_sec_timer.sv
// -----------------------------------------------------------------------------
// sec_timer
// Seconds counter with synchronous clear and terminal-count compare.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : clear count to zero (wins over tick_i)
//   tick_i    : one-clk 1 Hz strobe; advances the count
//   last_i    : terminal value; done_o fires on the tick that ends it
//   done_o    : tick_i & (count == last_i), combinational
// -----------------------------------------------------------------------------
module sec_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         tick_i,
    input  logic [W-1:0] last_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (tick_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = tick_i && (cnt_q == last_i);

endmodule

// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
// Owns the alarm session: ring, snooze, dismiss and ring timeout.
//   clk, rst    : clock, asynchronous active-high reset
//   tick_1hz    : one-clk strobe once per second
//   enable      : alarm armed; low forces IDLE
//   active      : alarm match level (a rising edge starts a session)
//   stop_btn    : one-clk dismiss pulse
//   snooze_btn  : one-clk snooze pulse
//   buzzer      : 1 s on / 1 s off while ringing
//   ringing     : high in RING
//   snoozed     : high in SNOOZE
//   snooze_cnt  : snoozes used in the current session
//   missed      : one-clk pulse when a ring phase times out
// -----------------------------------------------------------------------------
module alarm_ringer
    import watch_pkg::*;
#(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_1hz,
    input  logic                    enable,
    input  logic                    active,
    input  logic                    stop_btn,
    input  logic                    snooze_btn,
    output logic                    buzzer,
    output logic                    ringing,
    output logic                    snoozed,
    output logic [SNOOZE_CNT_W-1:0] snooze_cnt,
    output logic                    missed
);

    localparam int unsigned SEC_W = $clog2(max_u(RING_SECS, SNOOZE_SECS) + 1);
    localparam logic [SEC_W-1:0]        RING_LAST   = SEC_W'(RING_SECS - 1);
    localparam logic [SEC_W-1:0]        SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
    localparam logic [SNOOZE_CNT_W-1:0] SNZ_MAX     = SNOOZE_CNT_W'(MAX_SNOOZE);

    ring_state_e             state_q, state_d;
    logic                    active_q;
    logic [SNOOZE_CNT_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic                    buzzer_q, buzzer_d;
    logic                    missed_q, missed_d;
    logic                    ringing_q, snoozed_q;

    logic                    rise;
    logic                    restart;
    logic                    timer_clr;
    logic                    timer_done;
    logic [SEC_W-1:0]        timer_last;

    assign rise       = active && !active_q && enable;
    assign timer_last = (state_q == RING) ? RING_LAST : SNOOZE_LAST;

    sec_timer #(
        .W (SEC_W)
    ) u_sec_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr),
        .tick_i (tick_1hz),
        .last_i (timer_last),
        .done_o (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        buzzer_d     = 1'b0;
        missed_d     = 1'b0;
        restart      = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d      = RING;
                        snooze_cnt_d = '0;
                    end
                end
                RING: begin
                    buzzer_d = tick_1hz ? !buzzer_q : buzzer_q;
                    // A snooze at the limit is treated as if not pressed, so
                    // the timeout and rise checks below still apply.
                    if (stop_btn) begin
                        state_d = IDLE;
                    end else if (snooze_btn && (snooze_cnt_q < SNZ_MAX)) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 1'b1;
                    end else if (timer_done) begin
                        state_d  = IDLE;
                        missed_d = 1'b1;
                    end else if (rise) begin
                        restart = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = IDLE;
                    end else if (rise) begin
                        state_d      = RING;
                        snooze_cnt_d = '0;
                    end else if (timer_done) begin
                        state_d = RING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Entry into RING forces the beep on, overriding a coincident toggle.
        if ((state_d == RING) && (state_q != RING)) begin
            buzzer_d = 1'b1;
        end
        if (state_d != RING) begin
            buzzer_d = 1'b0;
        end

        // Held clear in IDLE so the count is always zero on any entry.
        timer_clr = (state_d != state_q) || restart || (state_q == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            active_q     <= 1'b0;
            snooze_cnt_q <= '0;
            buzzer_q     <= 1'b0;
            missed_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active;
            snooze_cnt_q <= snooze_cnt_d;
            buzzer_q     <= buzzer_d;
            missed_q     <= missed_d;
            ringing_q    <= (state_d == RING);
            snoozed_q    <= (state_d == SNOOZE);
        end
    end

    assign buzzer     = buzzer_q;
    assign ringing    = ringing_q;
    assign snoozed    = snoozed_q;
    assign snooze_cnt = snooze_cnt_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

    localparam int unsigned RS = 5;
    localparam int unsigned SS = 3;
    localparam int unsigned MS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       enable;
    logic       active;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozed;
    logic [3:0] snooze_cnt;
    logic       missed;

    always #5 clk = ~clk;

    alarm_ringer #(
        .RING_SECS   (RS),
        .SNOOZE_SECS (SS),
        .MAX_SNOOZE  (MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .enable     (enable),
        .active     (active),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .snooze_cnt (snooze_cnt),
        .missed     (missed)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_missed_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: session described by "is ringing", "is snoozing",
    // seconds elapsed in the current phase, ticks since the ring began
    // (beep is on for even tick counts) and snoozes used.
    bit m_ring, m_snz, m_missed, m_prev;
    int m_secs, m_rt, m_used;

    function automatic void model_reset();
        m_ring = 0; m_snz = 0; m_missed = 0; m_prev = 0;
        m_secs = 0; m_rt = 0; m_used = 0;
    endfunction

    function automatic void start_ring(input bit fresh);
        m_ring = 1; m_snz = 0; m_secs = 0; m_rt = 0;
        if (fresh) m_used = 0;
    endfunction

    function automatic void model_step(input bit en, input bit act, input bit stp,
                                       input bit snz, input bit tk);
        bit rise;
        rise = act && !m_prev && en;
        m_prev = act;
        m_missed = 0;
        if (!en) begin
            m_ring = 0; m_snz = 0;
        end else if (m_ring) begin
            if (stp) m_ring = 0;
            else if (snz && m_used < MS) begin
                m_ring = 0; m_snz = 1; m_used++; m_secs = 0;
            end else if (tk && m_secs == RS - 1) begin
                m_ring = 0; m_missed = 1;
            end else begin
                if (tk) begin m_secs++; m_rt++; end
                if (rise) m_secs = 0;
            end
        end else if (m_snz) begin
            if (stp) m_snz = 0;
            else if (rise) start_ring(1);
            else if (tk && m_secs == SS - 1) start_ring(0);
            else if (tk) m_secs++;
        end else if (rise) begin
            start_ring(1);
        end
    endfunction

    task automatic compare_all();
        check_eq("ringing",    ringing,    m_ring);
        check_eq("snoozed",    snoozed,    m_snz);
        check_eq("buzzer",     buzzer,     m_ring && (m_rt % 2 == 0));
        check_eq("snooze_cnt", snooze_cnt, m_used);
        check_eq("missed",     missed,     m_missed);
    endtask

    task automatic step(input bit stp, input bit snz, input bit tk);
        stop_btn = stp; snooze_btn = snz; tick_1hz = tk;
        @(posedge clk);
        model_step(enable, active, stp, snz, tk);
        #1;
        compare_all();
        if (missed === 1'b1) n_missed_seen++;
        stop_btn = 0; snooze_btn = 0; tick_1hz = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0);
            step(0, 0, 0);
            step(0, 0, 1);
        end
    endtask

    initial begin
        rst = 1; tick_1hz = 0; enable = 0; active = 0; stop_btn = 0; snooze_btn = 0;
        model_reset();
        #2;
        compare_all();
        #20;
        @(negedge clk);
        rst = 0;

        // 1: long-held active, no buttons -> timeout once, no re-ring
        enable = 1; active = 1;
        step(0, 0, 0);
        check_eq("t1_ring_after_rise", ringing, 1);
        n_missed_seen = 0;
        ticks(20);
        check_eq("t1_missed_pulses", n_missed_seen, 1);
        check_eq("t1_no_rering", ringing, 0);
        active = 0;
        step(0, 0, 0);

        // 2: stop after 2 ticks
        active = 1;
        step(0, 0, 0);
        n_missed_seen = 0;
        ticks(2);
        step(1, 0, 0);
        check_eq("t2_stopped", ringing, 0);
        check_eq("t2_buzzer_off", buzzer, 0);
        check_eq("t2_no_missed", n_missed_seen, 0);
        active = 0;
        step(0, 0, 0);

        // 3: snooze twice, third snooze ignored
        active = 1;
        step(0, 0, 0);
        ticks(1);
        step(0, 1, 0);
        check_eq("t3_snoozed1", snoozed, 1);
        check_eq("t3_cnt1", snooze_cnt, 1);
        ticks(3);
        check_eq("t3_rering1", ringing, 1);
        check_eq("t3_rering1_buz", buzzer, 1);
        step(0, 1, 0);
        check_eq("t3_cnt2", snooze_cnt, 2);
        ticks(3);
        check_eq("t3_rering2", ringing, 1);
        step(0, 1, 0);
        check_eq("t3_limit_ring", ringing, 1);
        check_eq("t3_limit_cnt", snooze_cnt, 2);

        // 4: stop and snooze together -> stop wins
        step(1, 1, 0);
        check_eq("t4_idle", ringing | snoozed, 0);
        check_eq("t4_cnt_held", snooze_cnt, 2);
        active = 0;
        step(0, 0, 0);

        // 5: enable drop in SNOOZE, then async reset mid-ring
        active = 1;
        step(0, 0, 0);
        step(0, 1, 0);
        enable = 0;
        n_missed_seen = 0;
        step(0, 0, 0);
        check_eq("t5_en_idle", snoozed | ringing, 0);
        check_eq("t5_en_no_missed", n_missed_seen, 0);
        enable = 1;
        step(0, 0, 0);
        active = 0;
        step(0, 0, 0);
        active = 1;
        step(0, 0, 0);
        ticks(1);
        rst = 1;
        #1;
        model_reset();
        check_eq("t5_rst_ringing", ringing, 0);
        check_eq("t5_rst_buzzer", buzzer, 0);
        check_eq("t5_rst_cnt", snooze_cnt, 0);
        #2;
        rst = 0;

        // 6: new rise during SNOOZE, coincident with a tick
        step(0, 0, 0);
        step(0, 1, 0);
        active = 0;
        step(0, 0, 0);
        active = 1;
        step(0, 0, 1);
        check_eq("t6_rering", ringing, 1);
        check_eq("t6_cnt0", snooze_cnt, 0);
        check_eq("t6_buz_entry", buzzer, 1);
        ticks(6);
        active = 0;

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) active = ~active;
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 19) == 0) enable = 1;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
